coef_cal_seq: RTL and testbench
===============================

# coef_cal_seq

Parametrised, frame-synchronous successor to the scaler coefficient calculator. On each vertical-sync rise it snapshots the crop window and output resolution, and checks the output pixel rate against a limit. One shared iterative restoring divider computes the rounded, saturated fixed-point reciprocal scale factors kX and kY. It sits between the register/config interface and the scaler's input controller and interpolator, and gates the input controller through inEn.

## Interface
- IN_RES_W, 11, width of input coordinates/resolutions
- OUT_RES_W, 11, width of output resolutions (value = count-1)
- FRAC_BITS, 6, fractional bits of k
- SCALE_BITS, 8, width of kX/kY
- FRAME_RATE, 100, frames/s used in rate check
- RATE_LIMIT, 133693440, max allowed (outX+1)*(outY+1)*FRAME_RATE
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable
- iVsyn  in  1  vertical sync, synchronous to clk, active-high
- xBgn, xEnd, yBgn, yEnd  in  IN_RES_W each  crop window, inclusive
- inXRes, inYRes  in  IN_RES_W  input resolution minus 1
- outXRes, outYRes  in  OUT_RES_W  output resolution minus 1
- kX, kY  out  SCALE_BITS  reciprocal scale factors
- kValid  out  1  one-cycle pulse when kX/kY update
- busy  out  1  calculation in progress
- inEn  out  1  enable to input controller
- cfgErr, rateErr, satX, satY  out  1  sticky status flags of the last attempt

## Operation
- Vsync edge: register iVsyn into vsD. A start is vsR = iVsyn & ~vsD & en & ~busy. Rises while busy or while en=0 are ignored, not queued.
- On start, all config inputs load into shadow registers and state IDLE→CHECK. The block ignores config inputs after that until the next start.
- CHECK, 1 cycle:
  - cfgErr if xEnd<xBgn, yEnd<yBgn, xEnd>inXRes or yEnd>inYRes.
  - rateErr if (outXRes+1)*(outYRes+1)*FRAME_RATE > RATE_LIMIT.
  - The product is computed full width: 2*(OUT_RES_W+1)+7 bits, no truncation.
  - On either error: go to ERR.
  - Otherwise: clear all four flags and go to DIVX.
- Divider quotient width: QW = IN_RES_W+FRAC_BITS.
  - Dividend = (End-Bgn+1) << FRAC_BITS, with End-Bgn+1 in IN_RES_W+1 bits.
  - Divisor = out*Res+1 in OUT_RES_W+1 bits; it is never zero.
- DIVX, QW cycles: restoring division, one quotient bit per cycle, MSB first. Quotient and remainder are held internally.
- DIVY, QW cycles: the same for the Y axis, using the same datapath.
- Rounding: q' = q + (2*rem >= divisor).
- Clamping: if q' > 2^SCALE_BITS-1, the result is all ones and satX/satY is set. If q' = 0, the result is 1.
- DONE, 1 cycle:
  - kX and kY load their rounded, clamped values.
  - kValid=1.
  - inEn is set if en is still 1.
  - Next state is IDLE.
- ERR, 1 cycle: inEn is cleared, kX/kY hold their previous values, kValid stays 0. Next state is IDLE.
- en=0 in any state clears inEn on the next clk edge. An operation already in progress still completes and updates k, but inEn stays 0.
- busy=1 in CHECK, DIVX, DIVY, DONE and ERR.

## Timing
- Reset values: kX=kY=1, kValid=0, busy=0, inEn=0, all flags 0. State is IDLE and vsD=0.
- Reset asserted mid-operation aborts immediately to these values. No partial k ever reaches the outputs.
- Latency: if the start is sampled at edge 0, kValid and the new kX/kY appear after edge 2*QW+2 (36 cycles for the defaults).
- Error path: the ERR flags and the inEn clear appear after edge 2.
- busy rises after edge 0 and falls together with the kValid/ERR cycle ending.
- kX and kY change only in the DONE cycle and stay stable for the whole frame.
- A vsync rise in the same cycle as DONE/ERR is ignored, because busy=1 in that cycle.

## Test plan
- Crop 0..639 × 0..359, outXRes=1279, outYRes=719, en=1, pulse iVsyn -> after 36 cycles kValid pulses with kX=32, kY=32, inEn=1 and no flags.
- Crop 0..1279 × 0..719, out 1919/1079 -> rateErr=1 (207,360,000 > limit), inEn=0, kX/kY unchanged.
- Crop 0..1919 × 0..1079, out 319/179 -> q=384 for both axes, so kX=kY=255 and satX=satY=1. Also crop 0..1279, out 1919 (X axis only) -> 42.67 rounds to kX=43.
- xBgn=100, xEnd=50 -> cfgErr=1 after edge 2, no kValid, inEn=0.
- Pulse iVsyn again 10 cycles into DIVX -> ignored, exactly one kValid. Next, assert rst mid-DIVY -> all outputs return to reset values asynchronously and kValid never fires.
- Drop en at cycle 20 of an operation -> inEn=0 next cycle. kValid still fires at cycle 36 with the new k and inEn stays 0.

Source files
------------

// File: rtl/coef_cal_seq.sv
// Frame-synchronous scaler coefficient calculator: snapshots crop/output config on vsync rise,
// checks config and pixel rate, then derives rounded, saturated kX/kY with one shared restoring divider.
module coef_cal_seq #(
  parameter int     IN_RES_W   = 11,
  parameter int     OUT_RES_W  = 11,
  parameter int     FRAC_BITS  = 6,
  parameter int     SCALE_BITS = 8,
  parameter int     FRAME_RATE = 100,
  parameter longint RATE_LIMIT = 133693440
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  iVsyn,
  input  logic [IN_RES_W-1:0]   xBgn,
  input  logic [IN_RES_W-1:0]   xEnd,
  input  logic [IN_RES_W-1:0]   yBgn,
  input  logic [IN_RES_W-1:0]   yEnd,
  input  logic [IN_RES_W-1:0]   inXRes,
  input  logic [IN_RES_W-1:0]   inYRes,
  input  logic [OUT_RES_W-1:0]  outXRes,
  input  logic [OUT_RES_W-1:0]  outYRes,
  output logic [SCALE_BITS-1:0] kX,
  output logic [SCALE_BITS-1:0] kY,
  output logic                  kValid,
  output logic                  busy,
  output logic                  inEn,
  output logic                  cfgErr,
  output logic                  rateErr,
  output logic                  satX,
  output logic                  satY
);

  localparam int QW = IN_RES_W + FRAC_BITS;
  localparam int DW = OUT_RES_W + 1;
  localparam int PW = 2 * (OUT_RES_W + 1) + 7;
  localparam int CW = $clog2(QW + 1);
  localparam logic [SCALE_BITS-1:0] K_MAX = {SCALE_BITS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DIVX, S_DIVY, S_DONE, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic                 vs_d;
  logic                 start;
  logic [IN_RES_W-1:0]  sh_xbgn, sh_xend, sh_ybgn, sh_yend, sh_inx, sh_iny;
  logic [OUT_RES_W-1:0] sh_outx, sh_outy;

  logic [QW-1:0]         acc;
  logic [DW-1:0]         rem, dvs;
  logic                  ovf;
  logic [CW-1:0]         cnt;
  logic                  last;
  logic [SCALE_BITS-1:0] kx_res, ky_res;
  logic                  satx_res, saty_res;

  assign busy  = (state != S_IDLE);
  assign start = iVsyn & ~vs_d & en & ~busy;
  assign last  = (cnt == CW'(QW - 1));

  logic            cfg_bad, rate_bad;
  logic [DW-1:0]   dvs_x, dvs_y;
  logic [PW-1:0]   rate_prod;
  logic [IN_RES_W:0] span_x, span_y;
  logic [QW:0]     dvd_x, dvd_y;

  assign cfg_bad   = (sh_xend < sh_xbgn) | (sh_yend < sh_ybgn) |
                     (sh_xend > sh_inx)  | (sh_yend > sh_iny);
  assign dvs_x     = {1'b0, sh_outx} + DW'(1);
  assign dvs_y     = {1'b0, sh_outy} + DW'(1);
  assign rate_prod = PW'(dvs_x) * PW'(dvs_y) * PW'(FRAME_RATE);
  assign rate_bad  = 64'(rate_prod) > 64'(RATE_LIMIT);
  assign span_x    = {1'b0, sh_xend} - {1'b0, sh_xbgn} + (IN_RES_W+1)'(1);
  assign span_y    = {1'b0, sh_yend} - {1'b0, sh_ybgn} + (IN_RES_W+1)'(1);
  assign dvd_x     = {span_x, {FRAC_BITS{1'b0}}};
  assign dvd_y     = {span_y, {FRAC_BITS{1'b0}}};

  // One restoring step: dividend bits leave acc at the top, quotient bits enter at the bottom.
  logic [DW:0]   rem_sh;
  logic          take;
  logic [DW-1:0] rem_n;
  logic [QW-1:0] acc_n;

  assign rem_sh = {rem, acc[QW-1]};
  assign take   = rem_sh >= {1'b0, dvs};
  assign rem_n  = take ? (rem_sh[DW-1:0] - dvs) : rem_sh[DW-1:0];
  assign acc_n  = {acc[QW-2:0], take};

  logic [DW:0]           rem2;
  logic                  rnd_up;
  logic [QW:0]           q_rnd;
  logic                  sat_n;
  logic [SCALE_BITS-1:0] k_n;

  assign rem2   = {rem_n, 1'b0};
  assign rnd_up = rem2 >= {1'b0, dvs};
  assign q_rnd  = {1'b0, acc_n} + (QW+1)'(rnd_up);
  assign sat_n  = ovf | (q_rnd > (QW+1)'(K_MAX));
  assign k_n    = sat_n ? K_MAX :
                  (q_rnd == '0) ? SCALE_BITS'(1) : q_rnd[SCALE_BITS-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (cfg_bad | rate_bad) ? S_ERR : S_DIVX;
      S_DIVX:  if (last) state_nxt = S_DIVY;
      S_DIVY:  if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d     <= 1'b0;
      sh_xbgn  <= '0; sh_xend <= '0; sh_ybgn <= '0; sh_yend <= '0;
      sh_inx   <= '0; sh_iny  <= '0; sh_outx <= '0; sh_outy <= '0;
      acc      <= '0; rem <= '0; dvs <= '0; ovf <= 1'b0; cnt <= '0;
      kx_res   <= SCALE_BITS'(1); ky_res <= SCALE_BITS'(1);
      satx_res <= 1'b0; saty_res <= 1'b0;
      kX       <= SCALE_BITS'(1); kY <= SCALE_BITS'(1);
      kValid   <= 1'b0; inEn <= 1'b0;
      cfgErr   <= 1'b0; rateErr <= 1'b0; satX <= 1'b0; satY <= 1'b0;
    end else begin
      vs_d   <= iVsyn;
      kValid <= 1'b0;
      if (start) begin
        sh_xbgn <= xBgn;   sh_xend <= xEnd;   sh_ybgn <= yBgn;   sh_yend <= yEnd;
        sh_inx  <= inXRes; sh_iny  <= inYRes; sh_outx <= outXRes; sh_outy <= outYRes;
      end
      case (state)
        S_CHECK: begin
          if (!(cfg_bad | rate_bad)) begin
            cfgErr <= 1'b0; rateErr <= 1'b0; satX <= 1'b0; satY <= 1'b0;
            acc <= dvd_x[QW-1:0];
            rem <= DW'(dvd_x[QW]);
            dvs <= dvs_x;
            // Only a full-width span over divisor 1 can start with rem >= divisor.
            ovf <= dvd_x[QW] & (dvs_x == DW'(1));
            cnt <= '0;
          end
        end
        S_DIVX: begin
          if (last) begin
            kx_res   <= k_n;
            satx_res <= sat_n;
            acc <= dvd_y[QW-1:0];
            rem <= DW'(dvd_y[QW]);
            dvs <= dvs_y;
            ovf <= dvd_y[QW] & (dvs_y == DW'(1));
            cnt <= '0;
          end else begin
            acc <= acc_n; rem <= rem_n; cnt <= cnt + CW'(1);
          end
        end
        S_DIVY: begin
          if (last) begin
            ky_res   <= k_n;
            saty_res <= sat_n;
          end else begin
            acc <= acc_n; rem <= rem_n; cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          kX     <= kx_res;
          kY     <= ky_res;
          satX   <= satx_res;
          satY   <= saty_res;
          kValid <= 1'b1;
        end
        S_ERR: begin
          cfgErr  <= cfg_bad;
          rateErr <= rate_bad;
          satX    <= 1'b0;
          satY    <= 1'b0;
        end
        default: ;
      endcase
      if (!en)                 inEn <= 1'b0;
      else if (state == S_DONE) inEn <= 1'b1;
      else if (state == S_ERR)  inEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coef_cal_seq.sv
// Scoreboard bench for coef_cal_seq: expected frame results are queued when a vsync is issued
// and compared against what the block reports for that frame.
module tb_coef_cal_seq;

  logic        clk = 1'b0;
  logic        rst, en, iVsyn;
  logic [10:0] xBgn, xEnd, yBgn, yEnd, inXRes, inYRes, outXRes, outYRes;
  logic [7:0]  kX, kY;
  logic        kValid, busy, inEn, cfgErr, rateErr, satX, satY;

  coef_cal_seq dut (
    .clk(clk), .rst(rst), .en(en), .iVsyn(iVsyn),
    .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd),
    .inXRes(inXRes), .inYRes(inYRes), .outXRes(outXRes), .outYRes(outYRes),
    .kX(kX), .kY(kY), .kValid(kValid), .busy(busy), .inEn(inEn),
    .cfgErr(cfgErr), .rateErr(rateErr), .satX(satX), .satY(satY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] kx, ky;
    logic       valid;
    logic [3:0] flags;   // {cfgErr, rateErr, satX, satY}
    logic       inen;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl_kx, mdl_ky;

  int         nvalid, vcyc;
  logic [7:0] o_kx, o_ky, r_kx, r_ky;
  logic [3:0] o_flags, e2_flags, r_flags;
  logic       o_inen, e2_inen, b5, b38, v_after, inen21, r_busy, r_inen, r_kvalid;

  function automatic void axis(input int b, input int en_, input int o,
                               output logic [7:0] k, output logic s);
    longint n, d, q, r;
    n = longint'(en_ - b + 1) * 64;
    d = longint'(o) + 1;
    q = n / d;
    r = n % d;
    if (2 * r >= d) q = q + 1;
    s = 1'b0;
    if (q > 255) begin k = 8'd255; s = 1'b1; end
    else if (q == 0) k = 8'd1;
    else k = 8'(q);
  endfunction

  task automatic push_expect(input logic en_end);
    exp_t x;
    logic cfg, rate, sx, sy;
    cfg  = (xEnd < xBgn) || (yEnd < yBgn) || (xEnd > inXRes) || (yEnd > inYRes);
    rate = (longint'(outXRes) + 1) * (longint'(outYRes) + 1) * 100 > 133693440;
    if (cfg || rate) begin
      x.kx = mdl_kx; x.ky = mdl_ky; x.valid = 1'b0;
      x.flags = {cfg, rate, 2'b00}; x.inen = 1'b0;
    end else begin
      axis(int'(xBgn), int'(xEnd), int'(outXRes), x.kx, sx);
      axis(int'(yBgn), int'(yEnd), int'(outYRes), x.ky, sy);
      x.valid = 1'b1; x.flags = {2'b00, sx, sy}; x.inen = en_end;
      mdl_kx = x.kx; mdl_ky = x.ky;
    end
    sb.push_back(x);
  endtask

  task automatic set_cfg(input int xb, input int xe, input int yb, input int ye,
                         input int ox, input int oy);
    xBgn = 11'(xb); xEnd = 11'(xe); yBgn = 11'(yb); yEnd = 11'(ye);
    inXRes = 11'd1919; inYRes = 11'd1079;
    outXRes = 11'(ox); outYRes = 11'(oy);
  endtask

  // Issues one vsync rise and watches a bounded 45-cycle window after the start edge.
  task automatic run_frame(input int drop_en_at, input int vs_again_at, input int rst_at);
    nvalid = 0; vcyc = -1; v_after = 1'bx;
    @(posedge clk); #1 iVsyn = 1'b1;
    @(posedge clk); #1 iVsyn = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      if (vcyc > 0 && n == vcyc + 1) v_after = kValid;
      if (kValid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = n; o_kx = kX; o_ky = kY;
          o_flags = {cfgErr, rateErr, satX, satY}; o_inen = inEn;
        end
      end
      if (n == 2)  begin e2_flags = {cfgErr, rateErr, satX, satY}; e2_inen = inEn; end
      if (n == 5)  b5 = busy;
      if (n == 21) inen21 = inEn;
      if (n == 38) b38 = busy;
      if (n == drop_en_at) en = 1'b0;
      if (n == vs_again_at) begin iVsyn = 1'b1; xBgn = 11'd1000; end
      if (n == vs_again_at + 1) iVsyn = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1; #1;
        r_kx = kX; r_ky = kY; r_busy = busy; r_inen = inEn; r_kvalid = kValid;
        r_flags = {cfgErr, rateErr, satX, satY};
      end
      if (n == rst_at + 1) rst = 1'b0;
    end
  endtask

  task automatic cmp_ok(input string name);
    e = sb.pop_front();
    checks++; if (nvalid !== 1)       begin errors++; $display("FAIL %s kvalid_count got %0d want 1", name, nvalid); end
    checks++; if (vcyc !== 36)        begin errors++; $display("FAIL %s latency got %0d want 36", name, vcyc); end
    checks++; if (o_kx !== e.kx)      begin errors++; $display("FAIL %s kX got %0d want %0d", name, o_kx, e.kx); end
    checks++; if (o_ky !== e.ky)      begin errors++; $display("FAIL %s kY got %0d want %0d", name, o_ky, e.ky); end
    checks++; if (o_flags !== e.flags) begin errors++; $display("FAIL %s flags got %b want %b", name, o_flags, e.flags); end
    checks++; if (o_inen !== e.inen)  begin errors++; $display("FAIL %s inEn got %b want %b", name, o_inen, e.inen); end
  endtask

  task automatic cmp_err(input string name);
    e = sb.pop_front();
    checks++; if (nvalid !== 0)        begin errors++; $display("FAIL %s kvalid_count got %0d want 0", name, nvalid); end
    checks++; if (e2_flags !== e.flags) begin errors++; $display("FAIL %s flags@2 got %b want %b", name, e2_flags, e.flags); end
    checks++; if (e2_inen !== 1'b0)    begin errors++; $display("FAIL %s inEn@2 got %b want 0", name, e2_inen); end
    checks++; if (kX !== e.kx || kY !== e.ky)
      begin errors++; $display("FAIL %s k_hold got %0d/%0d want %0d/%0d", name, kX, kY, e.kx, e.ky); end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; iVsyn = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    mdl_kx = 8'd1; mdl_ky = 8'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (kX !== 8'd1 || kY !== 8'd1)
      begin errors++; $display("FAIL reset_k got %0d/%0d want 1/1", kX, kY); end
    checks++; if ({kValid, busy, inEn} !== 3'b000)
      begin errors++; $display("FAIL reset_ctl got %b want 000", {kValid, busy, inEn}); end
    checks++; if ({cfgErr, rateErr, satX, satY} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {cfgErr, rateErr, satX, satY}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    set_cfg(0, 639, 0, 359, 1279, 719);
    push_expect(1'b1);
    run_frame(0, 0, 0);
    cmp_ok("basic");
    checks++; if (b5 !== 1'b1)      begin errors++; $display("FAIL basic_busy_mid got %b want 1", b5); end
    checks++; if (b38 !== 1'b0)     begin errors++; $display("FAIL basic_busy_end got %b want 0", b38); end
    checks++; if (v_after !== 1'b0) begin errors++; $display("FAIL basic_kvalid_width got %b want 0", v_after); end
  endtask

  task automatic test_rate_err;
    set_cfg(0, 1279, 0, 719, 1919, 1079);
    push_expect(1'b1);
    run_frame(0, 0, 0);
    cmp_err("rate_err");
  endtask

  task automatic test_saturate;
    set_cfg(0, 1919, 0, 1079, 319, 179);
    push_expect(1'b1);
    run_frame(0, 0, 0);
    cmp_ok("saturate");
    set_cfg(0, 1279, 0, 719, 1919, 599);
    push_expect(1'b1);
    run_frame(0, 0, 0);
    cmp_ok("round");
  endtask

  task automatic test_cfg_err;
    set_cfg(100, 50, 0, 359, 1279, 719);
    push_expect(1'b1);
    run_frame(0, 0, 0);
    cmp_err("cfg_err");
  endtask

  task automatic test_vsync_ignored;
    set_cfg(0, 639, 0, 359, 1279, 719);
    push_expect(1'b1);
    run_frame(0, 10, 0);
    cmp_ok("vsync_ignored");
  endtask

  task automatic test_reset_mid;
    set_cfg(0, 1279, 0, 719, 1919, 599);
    run_frame(0, 0, 25);
    mdl_kx = 8'd1; mdl_ky = 8'd1;
    checks++; if (r_kx !== 8'd1 || r_ky !== 8'd1)
      begin errors++; $display("FAIL rst_mid_k got %0d/%0d want 1/1", r_kx, r_ky); end
    checks++; if ({r_kvalid, r_busy, r_inen} !== 3'b000)
      begin errors++; $display("FAIL rst_mid_ctl got %b want 000", {r_kvalid, r_busy, r_inen}); end
    checks++; if (r_flags !== 4'b0000)
      begin errors++; $display("FAIL rst_mid_flags got %b want 0000", r_flags); end
    checks++; if (nvalid !== 0)
      begin errors++; $display("FAIL rst_mid_kvalid got %0d want 0", nvalid); end
  endtask

  task automatic test_drop_en;
    set_cfg(0, 1279, 0, 719, 1919, 599);
    push_expect(1'b1);
    run_frame(0, 0, 0);
    cmp_ok("pre_drop");
    set_cfg(0, 639, 0, 359, 1279, 719);
    push_expect(1'b0);
    run_frame(20, 0, 0);
    checks++; if (inen21 !== 1'b0) begin errors++; $display("FAIL drop_en_inen21 got %b want 0", inen21); end
    cmp_ok("drop_en");
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rate_err();
    test_saturate();
    test_cfg_err();
    test_vsync_ignored();
    test_reset_mid();
    test_drop_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
